// File: rtl/run_monitor_if.sv
// Control/status bundle between the host side and run_monitor.
// Optional retire/instret signals exist only when RUN_MONITOR_INSTRET_EN is defined.
interface run_monitor_if #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned PC_W  = 32
);
  logic             start;
  logic             clear;
  logic [PC_W-1:0]  pc;
  logic             pc_valid;
  logic [PC_W-1:0]  stop_pc;
  logic             stop_pc_en;
  logic [CNT_W-1:0] max_cycles;
  logic             run;
  logic             halted;
  logic [1:0]       cause;
  logic [CNT_W-1:0] cycles;
`ifdef RUN_MONITOR_INSTRET_EN
  logic             retire;
  logic [CNT_W-1:0] instret;

  modport master (
    output start, clear, pc, pc_valid, stop_pc, stop_pc_en, max_cycles, retire,
    input  run, halted, cause, cycles, instret
  );
  modport slave (
    input  start, clear, pc, pc_valid, stop_pc, stop_pc_en, max_cycles, retire,
    output run, halted, cause, cycles, instret
  );
`else
  modport master (
    output start, clear, pc, pc_valid, stop_pc, stop_pc_en, max_cycles,
    input  run, halted, cause, cycles
  );
  modport slave (
    input  start, clear, pc, pc_valid, stop_pc, stop_pc_en, max_cycles,
    output run, halted, cause, cycles
  );
`endif
endinterface

// File: rtl/run_monitor.sv
// Run controller: gates the CPU, counts RUN cycles, halts on cycle limit / PC match / self-loop.
// Define RUN_MONITOR_INSTRET_EN to add the retired-instruction counter.
module run_monitor #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned LOOP_N = 8,
  parameter int unsigned LOOP_W = 4
) (
  input  logic         clk,
  input  logic         reset,
  run_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic [1:0]        cause_q, cause_d;
  logic [LOOP_W-1:0] loop_q, loop_d;
  logic [PC_W-1:0]   last_pc_q, last_pc_d;

  logic [CNT_W:0]    cyc_inc;
  logic [CNT_W-1:0]  cyc_sat;
  logic [LOOP_W-1:0] loop_nx;
  logic              pc_hit, loop_hit, lim_hit;

  assign cyc_inc  = {1'b0, cycles_q} + (CNT_W+1)'(1);
  assign cyc_sat  = cyc_inc[CNT_W] ? '1 : cyc_inc[CNT_W-1:0];
  assign lim_hit  = (bus.max_cycles != '0) && (cyc_inc == {1'b0, bus.max_cycles});
  assign pc_hit   = bus.pc_valid && bus.stop_pc_en && (bus.pc == bus.stop_pc);

  // loop_q==0 only before the first valid PC of a run, so a stale last_pc never matches
  always_comb begin
    loop_nx = loop_q;
    if (bus.pc_valid) begin
      if ((loop_q == '0) || (bus.pc != last_pc_q)) loop_nx = LOOP_W'(1);
      else                                         loop_nx = loop_q + LOOP_W'(1);
    end
  end
  assign loop_hit = bus.pc_valid && (loop_nx == LOOP_W'(LOOP_N));

`ifdef RUN_MONITOR_INSTRET_EN
  logic [CNT_W-1:0] instret_q, instret_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cycles_q  <= '0;
      cause_q   <= '0;
      loop_q    <= '0;
      last_pc_q <= '0;
`ifdef RUN_MONITOR_INSTRET_EN
      instret_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cycles_q  <= cycles_d;
      cause_q   <= cause_d;
      loop_q    <= loop_d;
      last_pc_q <= last_pc_d;
`ifdef RUN_MONITOR_INSTRET_EN
      instret_q <= instret_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!bus.clear && bus.start) state_d = RUN;
      RUN:     if (bus.clear) state_d = IDLE;
               else if (pc_hit || loop_hit || lim_hit) state_d = HALTED;
      HALTED:  if (bus.clear) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // IDLE is only ever entered with everything zeroed, so it simply keeps it that way
  always_comb begin
    cycles_d  = cycles_q;
    cause_d   = cause_q;
    loop_d    = loop_q;
    last_pc_d = last_pc_q;
`ifdef RUN_MONITOR_INSTRET_EN
    instret_d = instret_q;
`endif
    unique case (state_q)
      RUN: begin
        if (bus.clear) begin
          cycles_d  = '0;
          cause_d   = '0;
          loop_d    = '0;
          last_pc_d = '0;
`ifdef RUN_MONITOR_INSTRET_EN
          instret_d = '0;
`endif
        end else begin
          cycles_d = cyc_sat;
          loop_d   = loop_nx;
          if (bus.pc_valid) last_pc_d = bus.pc;
          if (pc_hit)        cause_d = 2'd2;
          else if (loop_hit) cause_d = 2'd3;
          else if (lim_hit)  cause_d = 2'd1;
`ifdef RUN_MONITOR_INSTRET_EN
          if (bus.retire && (instret_q != '1)) instret_d = instret_q + CNT_W'(1);
`endif
        end
      end
      HALTED: begin
        if (bus.clear) begin
          cycles_d  = '0;
          cause_d   = '0;
          loop_d    = '0;
          last_pc_d = '0;
`ifdef RUN_MONITOR_INSTRET_EN
          instret_d = '0;
`endif
        end
      end
      default: begin
        cycles_d  = '0;
        cause_d   = '0;
        loop_d    = '0;
        last_pc_d = '0;
`ifdef RUN_MONITOR_INSTRET_EN
        instret_d = '0;
`endif
      end
    endcase
  end

  always_comb begin
    bus.run     = (state_q == RUN);
    bus.halted  = (state_q == HALTED);
    bus.cause   = cause_q;
    bus.cycles  = cycles_q;
`ifdef RUN_MONITOR_INSTRET_EN
    bus.instret = instret_q;
`endif
  end

endmodule

// File: tb/tb_run_monitor.sv
// Self-checking bench for run_monitor: vector table, directed corner sequences,
// and a randomized run against a PC-history reference model.
module tb_run_monitor;
  localparam int unsigned LOOP_N = 8;
  localparam longint unsigned MAX32 = 64'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  run_monitor_if #(.CNT_W(32), .PC_W(32)) bus ();
  run_monitor_if #(.CNT_W(4),  .PC_W(32)) bus4 ();

  run_monitor #(.CNT_W(32), .PC_W(32), .LOOP_N(LOOP_N), .LOOP_W(4)) dut (
    .clk(clk), .reset(rst), .bus(bus)
  );
  run_monitor #(.CNT_W(4), .PC_W(32), .LOOP_N(LOOP_N), .LOOP_W(4)) dut4 (
    .clk(clk), .reset(rst), .bus(bus4)
  );

  // reference model: mode 0 idle, 1 running, 2 halted
  int              m_mode;
  logic [1:0]      m_cause;
  longint unsigned m_cycles;
  logic [31:0]     hist[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_zero();
    m_mode = 0; m_cause = 2'd0; m_cycles = 0; hist.delete();
  endtask

  task automatic model_edge();
    bit pcm, lpm, lim;
    if (m_mode == 1) begin
      if (bus.clear) model_zero();
      else begin
        if (m_cycles != MAX32) m_cycles++;
        if (bus.pc_valid) hist.push_back(bus.pc);
        if (hist.size() > LOOP_N) void'(hist.pop_front());
        pcm = bus.pc_valid && bus.stop_pc_en && (bus.pc == bus.stop_pc);
        lpm = 1'b0;
        if (bus.pc_valid && hist.size() == LOOP_N) begin
          lpm = 1'b1;
          foreach (hist[k]) if (hist[k] != bus.pc) lpm = 1'b0;
        end
        lim = (bus.max_cycles != 0) && (m_cycles == bus.max_cycles);
        if (pcm)      begin m_mode = 2; m_cause = 2'd2; end
        else if (lpm) begin m_mode = 2; m_cause = 2'd3; end
        else if (lim) begin m_mode = 2; m_cause = 2'd1; end
      end
    end else if (m_mode == 2) begin
      if (bus.clear) model_zero();
    end else if (bus.start && !bus.clear) begin
      m_mode = 1; m_cycles = 0; hist.delete();
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.clear = 0; bus.pc = '0; bus.pc_valid = 0;
    bus.stop_pc = '0; bus.stop_pc_en = 0; bus.max_cycles = '0;
    bus4.start = 0; bus4.clear = 0; bus4.pc = '0; bus4.pc_valid = 0;
    bus4.stop_pc = '0; bus4.stop_pc_en = 0; bus4.max_cycles = '0;
`ifdef RUN_MONITOR_INSTRET_EN
    bus.retire = 0; bus4.retire = 0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_run", bus.run, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_cause", bus.cause, 0);
    chk("rst_cycles", bus.cycles, 0);
    rst = 1'b0;
    model_zero();
  endtask

  task automatic start_run();
    bus.start = 1; step(); bus.start = 0;
  endtask

  task automatic loop_run(input bit gaps, output int edges);
    do_reset();
    start_run();
    edges = 0;
    for (int e = 0; e < 40; e++) begin
      bus.pc = (e < 3) ? 32'(4 * e) : 32'hC;
      bus.pc_valid = !(gaps && (e == 5 || e == 7 || e == 9));
      step();
      edges++;
      if (bus.halted) break;
    end
  endtask

  task automatic prio_run(input bit en_last);
    do_reset();
    bus.max_cycles = 8; bus.stop_pc = 32'h80; bus.pc = 32'h80; bus.pc_valid = 1;
    start_run();
    for (int e = 0; e < 8; e++) begin
      bus.stop_pc_en = en_last && (e == 7);
      step();
      if (e < 7) chk("prio_early_halt", bus.halted, 0);
    end
    chk("prio_halted", bus.halted, 1);
    chk("prio_cause", bus.cause, en_last ? 2 : 3);
    chk("prio_cycles", bus.cycles, 8);
  endtask

  typedef struct {
    logic start, clear, pv;
    logic [31:0] pc;
    logic en;
    logic [31:0] spc, maxc;
    logic er, eh;
    logic [1:0] ec;
    logic [31:0] ecy;
  } vec_t;

  function automatic vec_t mk(logic st, logic cl, logic pv, logic [31:0] pc, logic en,
                              logic [31:0] spc, logic [31:0] maxc, logic er, logic eh,
                              logic [1:0] ec, logic [31:0] ecy);
    vec_t v;
    v.start = st; v.clear = cl; v.pv = pv; v.pc = pc; v.en = en; v.spc = spc;
    v.maxc = maxc; v.er = er; v.eh = eh; v.ec = ec; v.ecy = ecy;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required normal completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[15];
    int edges, e_plain, e_gap;
    logic [31:0] pc_sel;
    int unsigned r;

    //            st cl pv pc      en spc  max er eh ec cy
    tbl[0]  = mk(0, 0, 0, 32'h0,  0, 0,    0,  0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 32'h0,  0, 0,    0,  1, 0, 0, 0);
    tbl[2]  = mk(0, 0, 1, 32'h0,  0, 0,    0,  1, 0, 0, 1);
    tbl[3]  = mk(0, 0, 0, 32'h4,  0, 0,    0,  1, 0, 0, 2);
    tbl[4]  = mk(1, 0, 1, 32'h4,  0, 0,    0,  1, 0, 0, 3);
    tbl[5]  = mk(0, 0, 1, 32'h8,  1, 8,    0,  0, 1, 2, 4);
    tbl[6]  = mk(1, 0, 0, 32'h8,  0, 8,    0,  0, 1, 2, 4);
    tbl[7]  = mk(0, 1, 0, 32'h8,  0, 0,    0,  0, 0, 0, 0);
    tbl[8]  = mk(1, 0, 0, 32'h0,  0, 0,    3,  1, 0, 0, 0);
    tbl[9]  = mk(0, 0, 1, 32'h20, 0, 0,    3,  1, 0, 0, 1);
    tbl[10] = mk(0, 0, 1, 32'h24, 0, 0,    3,  1, 0, 0, 2);
    tbl[11] = mk(0, 0, 1, 32'h28, 0, 0,    3,  0, 1, 1, 3);
    tbl[12] = mk(0, 1, 0, 32'h0,  0, 0,    0,  0, 0, 0, 0);
    tbl[13] = mk(1, 0, 0, 32'h0,  0, 0,    0,  1, 0, 0, 0);
    tbl[14] = mk(0, 1, 0, 32'h0,  0, 0,    0,  0, 0, 0, 0);

    do_reset();
    foreach (tbl[i]) begin
      bus.start = tbl[i].start; bus.clear = tbl[i].clear; bus.pc_valid = tbl[i].pv;
      bus.pc = tbl[i].pc; bus.stop_pc_en = tbl[i].en; bus.stop_pc = tbl[i].spc;
      bus.max_cycles = tbl[i].maxc;
      step();
      chk($sformatf("tbl%0d_run", i), bus.run, tbl[i].er);
      chk($sformatf("tbl%0d_halted", i), bus.halted, tbl[i].eh);
      chk($sformatf("tbl%0d_cause", i), bus.cause, tbl[i].ec);
      chk($sformatf("tbl%0d_cycles", i), bus.cycles, tbl[i].ecy);
    end

    // cycle limit of 500
    do_reset();
    bus.max_cycles = 500;
    start_run();
    edges = 0;
    for (int i = 0; i < 600; i++) begin
      bus.pc = 32'(4 * i); bus.pc_valid = 1;
      step(); edges++;
      if (bus.halted) break;
    end
    chk("lim_edges", edges, 500);
    chk("lim_cause", bus.cause, 1);
    chk("lim_cycles", bus.cycles, 500);
    chk("lim_run", bus.run, 0);

    // PC match at 0x40
    do_reset();
    bus.stop_pc = 32'h40; bus.stop_pc_en = 1;
    start_run();
    edges = 0;
    for (int i = 0; i < 40; i++) begin
      bus.pc = 32'(4 * i); bus.pc_valid = 1;
      step(); edges++;
      if (bus.halted) break;
    end
    chk("pcm_edges", edges, 17);
    chk("pcm_cause", bus.cause, 2);
    chk("pcm_cycles", bus.cycles, 17);
    bus.pc = 32'h44; step();
    chk("pcm_hold_cycles", bus.cycles, 17);

    // self-loop, then the same with three invalid cycles inside the loop
    loop_run(0, e_plain);
    chk("loop_edges", e_plain, 11);
    chk("loop_cause", bus.cause, 3);
    chk("loop_cycles", bus.cycles, 11);
    loop_run(1, e_gap);
    chk("loop_gap_delay", e_gap - e_plain, 3);
    chk("loop_gap_cause", bus.cause, 3);
    chk("loop_gap_cycles", bus.cycles, 14);

    prio_run(1);
    prio_run(0);

    // start ignored in RUN, clear at cycle 10 aborts
    do_reset();
    start_run();
    for (int i = 1; i <= 9; i++) begin
      bus.start = (i == 3);
      step();
    end
    bus.start = 0;
    chk("ctl_cycles9", bus.cycles, 9);
    chk("ctl_run", bus.run, 1);
    bus.clear = 1; step(); bus.clear = 0;
    chk("ctl_clr_run", bus.run, 0);
    chk("ctl_clr_cycles", bus.cycles, 0);
    chk("ctl_clr_halted", bus.halted, 0);

    // asynchronous reset mid-cycle
    start_run();
    step(); step(); step();
    chk("arst_pre_cycles", bus.cycles, 3);
    #3 rst = 1'b1;
    #1;
    chk("arst_run", bus.run, 0);
    chk("arst_cycles", bus.cycles, 0);
    #2 rst = 1'b0;
    model_zero();
    step();
    chk("arst_stays_idle", bus.run, 0);

    // 4-bit counter saturation
    do_reset();
    bus4.start = 1; step(); bus4.start = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 15) chk("sat_cycles15", bus4.cycles, 15);
    end
    chk("sat_cycles20", bus4.cycles, 15);
    chk("sat_run", bus4.run, 1);
    bus4.clear = 1; step(); bus4.clear = 0;
    chk("sat_clear", bus4.cycles, 0);

`ifdef RUN_MONITOR_INSTRET_EN
    do_reset();
    bus.retire = 1; step();
    chk("ir_idle", bus.instret, 0);
    start_run();
    for (int i = 0; i < 10; i++) begin
      bus.retire = (i % 2 == 0);
      step();
    end
    bus.retire = 0;
    chk("ir_count", bus.instret, 5);
    bus.clear = 1; step(); bus.clear = 0;
    chk("ir_clear", bus.instret, 0);
`endif

    // randomized run against the model
    do_reset();
    pc_sel = '0;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      bus.start = (r < 6);
      bus.clear = (r >= 97);
      if ($urandom_range(0, 9) < 4) pc_sel = 32'($urandom_range(0, 15) * 4);
      bus.pc = pc_sel;
      bus.pc_valid = ($urandom_range(0, 9) < 8);
      if (i % 50 == 0) begin
        bus.stop_pc = 32'($urandom_range(0, 15) * 4);
        bus.stop_pc_en = ($urandom_range(0, 3) == 0);
      end
      if (i % 150 == 0) bus.max_cycles = 32'($urandom_range(0, 40));
      step();
      chk("rnd_run", bus.run, m_mode == 1);
      chk("rnd_halted", bus.halted, m_mode == 2);
      chk("rnd_cause", bus.cause, m_cause);
      chk("rnd_cycles", bus.cycles, m_cycles);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
